calc_seq_ctrl: RTL and testbench
================================

# calc_seq_ctrl

Sequencing controller for the calculator's 4-bit combinational ALU. It collects operand A, operand B and the operation code from board switches, one confirmed by each Enter press. It then drives the ALU for one execute cycle, registers the result with carry/borrow and error flags, and holds it for the HEX display. It sits between the board I/O (switches, buttons) and the ALU/display path.

## Interface
Parameters:
- SYNC_STAGES, 2, synchronizer depth for btn_enter (minimum 2)

Ports:
- clk  input  1  system clock; the block uses this single clock
- rst  input  1  reset, synchronous to clk and active-high
- sw  input  4  operand value from switches
- op_sel  input  3  operation code from switches (000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT)
- btn_enter  input  1  raw Enter button level, asynchronous
- btn_clear  input  1  clear request, already debounced, synchronous level
- alu_a  output  4  operand A to ALU (a_reg)
- alu_b  output  4  operand B to ALU (b_reg)
- alu_op  output  3  op code to ALU (op_reg)
- alu_result  input  4  combinational result from ALU
- disp_val  output  4  value for HEX display
- state_led  output  5  one-hot current state {SHOW, EXEC, GET_OP, GET_B, GET_A}
- done  output  1  high while a result is held (SHOW)
- carry  output  1  ADD carry-out / SUB borrow of the held result
- err  output  1  held op code was invalid (110/111)

## Operation
- States: GET_A (reset state), GET_B, GET_OP, EXEC, SHOW.
- enter_pulse: a one-cycle pulse generated on each rising edge of synchronized btn_enter.
- GET_A + enter_pulse: a_reg<=sw, go to GET_B.
- GET_B + enter_pulse: b_reg<=sw, go to GET_OP.
- GET_OP + enter_pulse: op_reg<=op_sel, go to EXEC.
- EXEC: unconditional, exactly one cycle.
  - res<=alu_result.
  - Valid op: err<=0.
  - Invalid op (110/111): res<=0, err<=1.
  - carry: for ADD, carry<=bit 4 of the 5-bit sum {1'b0,a_reg}+{1'b0,b_reg}.
  - carry: for SUB, carry<=(a_reg<b_reg), i.e. borrow.
  - carry: all other ops, carry<=0.
  - Go to SHOW.
- SHOW: done=1, disp_val=res. On enter_pulse the next state depends on configuration (see Configuration).
- enter_pulse arriving in EXEC is ignored.
- disp_val by state:
  - GET_A and GET_B: sw (live).
  - GET_OP: {1'b0,op_sel}.
  - EXEC: res (previous value).
  - SHOW: res.
- btn_clear (any state): next state GET_A; a_reg, b_reg, op_reg, res, carry and err are cleared to 0.
- btn_clear has priority over a simultaneous enter_pulse.
- Reset values: state GET_A, all registers 0.
  - alu_a=0, alu_b=0, alu_op=0, disp_val=sw, state_led=00001, done=0, carry=0, err=0.
  - Synchronizer and edge flops reset to 0, so a button held through reset produces no pulse.
- Reset asserted mid-sequence overrides everything; the block restarts in GET_A.
- Arithmetic wraps modulo 16 in res; overflow is reported only via carry.

## Timing
- Enter latency: btn_enter first sampled high at edge N → state and capture register update at edge N+SYNC_STAGES+1. With the default, that is edge N+3.
- Holding btn_enter high yields exactly one pulse; a new pulse needs a low level to be sampled for at least one cycle.
- GET_OP→SHOW: the enter edge moves to EXEC, then the next edge to SHOW. done and the flags are valid one cycle after leaving GET_OP.
- All outputs are registered or decoded from registered state, except disp_val in GET_A/GET_B/GET_OP, which is combinational from sw/op_sel.

## Configuration
- CALC_CHAIN_EN defined: SHOW + enter_pulse sets a_reg<=res, clears carry/err, and goes to GET_B. This chains the previous result as operand A.
- CALC_CHAIN_EN undefined: SHOW + enter_pulse goes to GET_A; a_reg, b_reg and op_reg are kept until overwritten.

## Structure
- Shared package calc_pkg:
  - state enum (GET_A..SHOW),
  - op code constants OP_ADD..OP_NOT,
  - widths DATA_W=4 and OP_W=3.
- One sub-module, btn_edge_pulse: SYNC_STAGES-flop synchronizer plus a rising-edge detector with synchronous reset, producing enter_pulse.
- The ALU stays external, connected via alu_a/alu_b/alu_op/alu_result.

## Test plan
- Reset, then sw=5 enter, sw=3 enter, op_sel=000 enter → SHOW with disp_val=8, carry=0, err=0, done=1. Check the 3-cycle enter latency and the single EXEC cycle.
- A=9, B=8, ADD → disp_val=1, carry=1. A=3, B=5, SUB → disp_val=E, carry=1. A=5, B=3, SUB → disp_val=2, carry=0.
- op_sel=110 → res=0, err=1. Next run with a valid op clears err.
- btn_enter held high for 20 cycles in GET_A → exactly one advance to GET_B. btn_clear asserted in the same cycle as enter_pulse in GET_B → GET_A, registers 0.
- CALC_CHAIN_EN: 7+2=9, then enter → GET_B with alu_a=9; B=4, op XOR → disp_val=D. Without the macro, the same enter → GET_A.
- rst asserted in GET_OP with btn_enter held → all outputs at reset values next cycle, and no spurious advance after rst deasserts.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator sequencing controller.
// Contents: state enum (one-hot, so it doubles as the state LED pattern),
// op code constants, data/op widths and an op-code validity helper.
package calc_pkg;

  localparam int DATA_W = 4;
  localparam int OP_W   = 3;

  // One-hot encoding; bit order matches state_led {SHOW,EXEC,GET_OP,GET_B,GET_A}.
  typedef enum logic [4:0] {
    S_GET_A  = 5'b00001,
    S_GET_B  = 5'b00010,
    S_GET_OP = 5'b00100,
    S_EXEC   = 5'b01000,
    S_SHOW   = 5'b10000
  } state_e;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR = 3'b100;
  localparam logic [OP_W-1:0] OP_NOT = 3'b101;

  // 110 and 111 are unassigned and reported as errors.
  function automatic logic op_valid(input logic [OP_W-1:0] op);
    return (op <= OP_NOT);
  endfunction

endpackage

// File: rtl/btn_edge_pulse.sv
// Button synchronizer + rising-edge detector.
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset
//   i_btn    raw asynchronous button level
//   o_pulse  registered one-cycle pulse per rising edge of the synchronized level
// Latency: level first sampled at edge N -> o_pulse high after edge N+SYNC_STAGES.
// SYNC_STAGES must be at least 2.
module btn_edge_pulse #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_pulse
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES:0]   r_vld;   // marks which stages hold post-reset samples
  logic                   r_prev;
  logic                   r_pulse;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= '0;
      r_vld   <= '0;
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_btn};
      r_vld   <= {r_vld[SYNC_STAGES-1:0], 1'b1};
      r_prev  <= r_sync[SYNC_STAGES-1];
      // The zeros loaded by reset are not real samples: only fire once r_prev
      // holds a genuine level, so a button held through reset never pulses.
      r_pulse <= r_sync[SYNC_STAGES-1] & ~r_prev & r_vld[SYNC_STAGES];
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/calc_seq_ctrl.sv
// Calculator sequencing controller: collects A, B and op code on successive
// Enter presses, drives the external ALU for one EXEC cycle, and holds the
// result with carry/borrow and error flags for the display.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   sw, op_sel            switch operand / op code
//   btn_enter             raw asynchronous Enter button
//   btn_clear             synchronous clear (priority over Enter)
//   alu_a/alu_b/alu_op    registered operands/op to the ALU
//   alu_result            combinational ALU result
//   disp_val              display value (live switches while collecting)
//   state_led             one-hot state
//   done, carry, err      result-held flag and held result flags
// Build option: CALC_CHAIN_EN - Enter in SHOW chains the result into A and
// resumes at GET_B; otherwise Enter in SHOW returns to GET_A.
module calc_seq_ctrl
  import calc_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sw,
  input  logic [OP_W-1:0]   op_sel,
  input  logic              btn_enter,
  input  logic              btn_clear,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] disp_val,
  output logic [4:0]        state_led,
  output logic              done,
  output logic              carry,
  output logic              err
);

  state_e            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_a, r_b, r_res;
  logic [DATA_W-1:0] w_a_nxt, w_b_nxt, w_res_nxt;
  logic [OP_W-1:0]   r_op, w_op_nxt;
  logic              r_carry, r_err, w_carry_nxt, w_err_nxt;
  logic              w_enter;
  logic [DATA_W:0]   w_sum;

  btn_edge_pulse #(.SYNC_STAGES(SYNC_STAGES)) u_enter (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (btn_enter),
    .o_pulse (w_enter)
  );

  assign w_sum = {1'b0, r_a} + {1'b0, r_b};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_GET_A;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_op    <= w_op_nxt;
      r_res   <= w_res_nxt;
      r_carry <= w_carry_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_op_nxt    = r_op;
    w_res_nxt   = r_res;
    w_carry_nxt = r_carry;
    w_err_nxt   = r_err;
    if (btn_clear) begin
      w_state_nxt = S_GET_A;
      w_a_nxt     = '0;
      w_b_nxt     = '0;
      w_op_nxt    = '0;
      w_res_nxt   = '0;
      w_carry_nxt = 1'b0;
      w_err_nxt   = 1'b0;
    end else begin
      case (r_state)
        S_GET_A: if (w_enter) begin
          w_a_nxt     = sw;
          w_state_nxt = S_GET_B;
        end
        S_GET_B: if (w_enter) begin
          w_b_nxt     = sw;
          w_state_nxt = S_GET_OP;
        end
        S_GET_OP: if (w_enter) begin
          w_op_nxt    = op_sel;
          w_state_nxt = S_EXEC;
        end
        // Single-cycle execute; an Enter pulse landing here is dropped.
        S_EXEC: begin
          w_state_nxt = S_SHOW;
          if (op_valid(r_op)) begin
            w_res_nxt = alu_result;
            w_err_nxt = 1'b0;
            case (r_op)
              OP_ADD:  w_carry_nxt = w_sum[DATA_W];
              OP_SUB:  w_carry_nxt = (r_a < r_b);
              default: w_carry_nxt = 1'b0;
            endcase
          end else begin
            w_res_nxt   = '0;
            w_err_nxt   = 1'b1;
            w_carry_nxt = 1'b0;
          end
        end
        S_SHOW: if (w_enter) begin
`ifdef CALC_CHAIN_EN
          w_a_nxt     = r_res;
          w_carry_nxt = 1'b0;
          w_err_nxt   = 1'b0;
          w_state_nxt = S_GET_B;
`else
          w_state_nxt = S_GET_A;
`endif
        end
        default: w_state_nxt = S_GET_A;
      endcase
    end
  end

  always_comb begin
    disp_val = r_res;
    case (r_state)
      S_GET_A, S_GET_B: disp_val = sw;
      S_GET_OP:         disp_val = {1'b0, op_sel};
      default:          disp_val = r_res;
    endcase
  end

  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign alu_op    = r_op;
  assign state_led = r_state;
  assign done      = (r_state == S_SHOW);
  assign carry     = r_carry;
  assign err       = r_err;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Bench for calc_seq_ctrl: directed test-plan steps plus randomized
// operand/op sequences, compared every cycle against a press-level model.
module tb_calc_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sw = '0;
  logic [2:0] op_sel = '0;
  logic       btn_enter = 1'b0;
  logic       btn_clear = 1'b0;
  logic [3:0] alu_a, alu_b, alu_result, disp_val;
  logic [2:0] alu_op;
  logic [4:0] state_led;
  logic       done, carry, err;

  int n_chk = 0, n_pass = 0, n_fail = 0;

  // model: state index 0=GET_A 1=GET_B 2=GET_OP 3=EXEC 4=SHOW
  int         ms = 0;
  logic [3:0] ma = '0, mb = '0, mres = '0;
  logic [2:0] mop = '0;
  logic       mc = 1'b0, me = 1'b0;

  always #5 clk = ~clk;

  calc_seq_ctrl #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sw(sw), .op_sel(op_sel), .btn_enter(btn_enter),
    .btn_clear(btn_clear), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .disp_val(disp_val), .state_led(state_led),
    .done(done), .carry(carry), .err(err)
  );

  // Stand-in ALU; invalid codes return nonzero so forcing res to 0 is visible.
  always_comb begin
    alu_result = 4'hA;
    case (alu_op)
      3'd0: alu_result = alu_a + alu_b;
      3'd1: alu_result = alu_a - alu_b;
      3'd2: alu_result = alu_a & alu_b;
      3'd3: alu_result = alu_a | alu_b;
      3'd4: alu_result = alu_a ^ alu_b;
      3'd5: alu_result = ~alu_a;
      default: alu_result = 4'hA;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [3:0] edisp;
    case (ms)
      0, 1:    edisp = sw;
      2:       edisp = {1'b0, op_sel};
      default: edisp = mres;
    endcase
    chk({tag, ".led"},   state_led, 32'(1 << ms));
    chk({tag, ".a"},     alu_a, ma);
    chk({tag, ".b"},     alu_b, mb);
    chk({tag, ".op"},    alu_op, mop);
    chk({tag, ".disp"},  disp_val, edisp);
    chk({tag, ".done"},  done, (ms == 4));
    chk({tag, ".carry"}, carry, mc);
    chk({tag, ".err"},   err, me);
  endtask

  task automatic exec_model();
    int sa, sb;
    sa = ma; sb = mb;
    mc = 1'b0; me = 1'b0;
    case (mop)
      3'd0: begin mres = 4'((sa + sb) % 16); mc = (sa + sb) > 15; end
      3'd1: begin mres = 4'((sa - sb + 16) % 16); mc = sa < sb; end
      3'd2: mres = ma & mb;
      3'd3: mres = ma | mb;
      3'd4: mres = ma ^ mb;
      3'd5: mres = 4'(15 - sa);
      default: begin mres = 4'd0; me = 1'b1; end
    endcase
  endtask

  // One clock edge; ent says the bench expects an Enter pulse to act at it.
  task automatic step(input bit ent, input string tag);
    @(posedge clk);
    if (rst || btn_clear) begin
      ms = 0; ma = '0; mb = '0; mop = '0; mres = '0; mc = 1'b0; me = 1'b0;
    end else begin
      case (ms)
        0: if (ent) begin ma = sw; ms = 1; end
        1: if (ent) begin mb = sw; ms = 2; end
        2: if (ent) begin mop = op_sel; ms = 3; end
        3: begin exec_model(); ms = 4; end
        default: if (ent) begin
`ifdef CALC_CHAIN_EN
          ma = mres; mc = 1'b0; me = 1'b0; ms = 1;
`else
          ms = 0;
`endif
        end
      endcase
    end
    @(negedge clk);
    check_all(tag);
  endtask

  // Enter press: acts at the 4th edge after the button is first sampled.
  task automatic press(input logic [3:0] s, input logic [2:0] o, input bit clr);
    sw = s; op_sel = o; btn_enter = 1'b1;
    repeat (3) step(1'b0, "lat");
    btn_clear = clr;
    step(1'b1, "ent");
    btn_clear = 1'b0;
    btn_enter = 1'b0;
    repeat (3) step(1'b0, "idle");
  endtask

  task automatic clear();
    btn_clear = 1'b1;
    step(1'b0, "clr");
    btn_clear = 1'b0;
    step(1'b0, "clr_idle");
  endtask

  task automatic run_any(input logic [3:0] a, input logic [3:0] b, input logic [2:0] o);
    if (ms == 4) press(4'd0, 3'd0, 1'b0);
    if (ms == 0) press(a, 3'd0, 1'b0);
    press(b, 3'd0, 1'b0);
    press(4'd0, o, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) step(1'b0, "rst");
    chk("rst_led", state_led, 5'b00001);
    rst = 1'b0;
    repeat (4) step(1'b0, "post_rst");

    // 5 + 3
    run_any(4'd5, 4'd3, 3'b000);
    chk("add53_disp", disp_val, 4'h8);
    chk("add53_carry", carry, 1'b0);
    chk("add53_done", done, 1'b1);

    clear(); run_any(4'd9, 4'd8, 3'b000);
    chk("add98_disp", disp_val, 4'h1);
    chk("add98_carry", carry, 1'b1);
    clear(); run_any(4'd3, 4'd5, 3'b001);
    chk("sub35_disp", disp_val, 4'hE);
    chk("sub35_borrow", carry, 1'b1);
    clear(); run_any(4'd5, 4'd3, 3'b001);
    chk("sub53_disp", disp_val, 4'h2);
    chk("sub53_borrow", carry, 1'b0);

    // invalid op, then a valid run without clearing
    clear(); run_any(4'd7, 4'd6, 3'b110);
    chk("inv_disp", disp_val, 4'h0);
    chk("inv_err", err, 1'b1);
    run_any(4'd1, 4'd1, 3'b011);
    chk("after_inv_err", err, 1'b0);

    // Enter held 20 cycles: one advance only
    clear();
    sw = 4'd6; btn_enter = 1'b1;
    repeat (3) step(1'b0, "hold_lat");
    step(1'b1, "hold_ent");
    repeat (16) step(1'b0, "hold");
    btn_enter = 1'b0;
    repeat (3) step(1'b0, "hold_rel");
    chk("hold_led", state_led, 5'b00010);
    chk("hold_a", alu_a, 4'd6);

    // clear coincident with the Enter pulse in GET_B
    press(4'd4, 3'd0, 1'b1);
    chk("clr_led", state_led, 5'b00001);
    chk("clr_a", alu_a, 4'd0);

    // chaining
    clear(); run_any(4'd7, 4'd2, 3'b000);
    chk("chain_sum", disp_val, 4'h9);
    press(4'd0, 3'd0, 1'b0);
`ifdef CALC_CHAIN_EN
    chk("chain_led", state_led, 5'b00010);
    chk("chain_a", alu_a, 4'd9);
    press(4'd4, 3'd0, 1'b0);
    press(4'd0, 3'b100, 1'b0);
    chk("chain_xor", disp_val, 4'hD);
`else
    chk("nochain_led", state_led, 5'b00001);
`endif

    // reset in GET_OP with Enter held
    clear();
    press(4'd1, 3'd0, 1'b0);
    press(4'd2, 3'd0, 1'b0);
    btn_enter = 1'b1; rst = 1'b1;
    step(1'b0, "mid_rst");
    chk("mid_rst_led", state_led, 5'b00001);
    chk("mid_rst_b", alu_b, 4'd0);
    step(1'b0, "mid_rst2");
    rst = 1'b0;
    repeat (10) step(1'b0, "rst_held_btn");
    btn_enter = 1'b0;
    repeat (3) step(1'b0, "rst_rel");

    // randomized sequences
    for (int i = 0; i < 20; i++) begin
      run_any(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              3'($urandom_range(0, 7)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
